// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with stall, flush, bubble insertion, a valid bit and delay-slot feedback.
// Optional performance counters for bubble and hold cycles are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_pipe #(
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3,
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int EXC_W    = 32,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_id,
   input  logic                stall_ex,
   input  logic                flush,
   input  logic                id_valid,
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [DATA_W-1:0]   id_reg1,
   input  logic [DATA_W-1:0]   id_reg2,
   input  logic [RADDR_W-1:0]  id_wd,
   input  logic                id_wreg,
   input  logic [DATA_W-1:0]   id_link_address,
   input  logic [DATA_W-1:0]   id_inst,
   input  logic [DATA_W-1:0]   id_pc,
   input  logic [EXC_W-1:0]    id_excepttype,
   input  logic                id_is_in_delayslot,
   input  logic                id_next_inst_in_delayslot,
   output logic                ex_valid,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [DATA_W-1:0]   ex_reg1,
   output logic [DATA_W-1:0]   ex_reg2,
   output logic [RADDR_W-1:0]  ex_wd,
   output logic                ex_wreg,
   output logic [DATA_W-1:0]   ex_link_address,
   output logic [DATA_W-1:0]   ex_inst,
   output logic [DATA_W-1:0]   ex_pc,
   output logic [EXC_W-1:0]    ex_excepttype,
   output logic                ex_is_in_delayslot,
`ifdef ID_EX_PERF_CNT_EN
   output logic [CNT_W-1:0]    bubble_cnt,
   output logic [CNT_W-1:0]    stall_cnt,
`endif
   output logic                is_in_delayslot_o
);

   typedef struct packed {
      logic                valid;
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [DATA_W-1:0]   reg1;
      logic [DATA_W-1:0]   reg2;
      logic [RADDR_W-1:0]  wd;
      logic                wreg;
      logic [DATA_W-1:0]   link_address;
      logic [DATA_W-1:0]   inst;
      logic [DATA_W-1:0]   pc;
      logic [EXC_W-1:0]    excepttype;
      logic                is_in_delayslot;
   } ex_pkt_t;

   typedef enum logic [1:0] {
      ACT_FLUSH   = 2'd0,
      ACT_HOLD    = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_ADVANCE = 2'd3
   } act_e;

   act_e    act;
   ex_pkt_t pkt_q, pkt_d;
   logic    ds_q, ds_d;

   // Priority after reset: flush, hold, bubble, advance.
   always_comb begin
      act = ACT_ADVANCE;
      if (flush)         act = ACT_FLUSH;
      else if (stall_ex) act = ACT_HOLD;
      else if (stall_id) act = ACT_BUBBLE;
   end

   always_comb begin
      pkt_d = pkt_q;
      ds_d  = ds_q;
      case (act)
         ACT_FLUSH: begin
            pkt_d = '0;
            ds_d  = 1'b0;
         end
         ACT_HOLD: ;
         // Delay-slot feedback holds so the branch is re-presented when decode resumes.
         ACT_BUBBLE: pkt_d = '0;
         default: begin
            pkt_d.valid           = id_valid;
            pkt_d.aluop           = id_aluop;
            pkt_d.alusel          = id_alusel;
            pkt_d.reg1            = id_reg1;
            pkt_d.reg2            = id_reg2;
            pkt_d.wd              = id_wd;
            pkt_d.wreg            = id_wreg & id_valid;
            pkt_d.link_address    = id_link_address;
            pkt_d.inst            = id_inst;
            pkt_d.pc              = id_pc;
            pkt_d.excepttype      = id_excepttype;
            pkt_d.is_in_delayslot = id_is_in_delayslot;
            ds_d                  = id_next_inst_in_delayslot;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_q <= '0;
         ds_q  <= 1'b0;
      end else begin
         pkt_q <= pkt_d;
         ds_q  <= ds_d;
      end
   end

   assign ex_valid           = pkt_q.valid;
   assign ex_aluop           = pkt_q.aluop;
   assign ex_alusel          = pkt_q.alusel;
   assign ex_reg1            = pkt_q.reg1;
   assign ex_reg2            = pkt_q.reg2;
   assign ex_wd              = pkt_q.wd;
   assign ex_wreg            = pkt_q.wreg;
   assign ex_link_address    = pkt_q.link_address;
   assign ex_inst            = pkt_q.inst;
   assign ex_pc              = pkt_q.pc;
   assign ex_excepttype      = pkt_q.excepttype;
   assign ex_is_in_delayslot = pkt_q.is_in_delayslot;
   assign is_in_delayslot_o  = ds_q;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating counters; flush cycles count as neither bubble nor hold.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (act == ACT_BUBBLE && !(&bubble_cnt_q)) bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (act == ACT_HOLD && !(&stall_cnt_q))    stall_cnt_d  = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, hold, bubble, delay slot, flush, invalid write, back-to-back.
// Counter checks are compiled in when ID_EX_PERF_CNT_EN is defined (counters instantiated 4 bits wide).
module tb_id_ex_pipe;
`ifdef ID_EX_PERF_CNT_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 32;
`endif

   logic        clk = 1'b0;
   logic        rst, stall_id, stall_ex, flush, id_valid;
   logic [7:0]  id_aluop;
   logic [2:0]  id_alusel;
   logic [31:0] id_reg1, id_reg2, id_link_address, id_inst, id_pc, id_excepttype;
   logic [4:0]  id_wd;
   logic        id_wreg, id_is_in_delayslot, id_next_inst_in_delayslot;
   logic        ex_valid, ex_wreg, ex_is_in_delayslot, is_in_delayslot_o;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [31:0] ex_reg1, ex_reg2, ex_link_address, ex_inst, ex_pc, ex_excepttype;
   logic [4:0]  ex_wd;
`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt, stall_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   id_ex_pipe #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex), .flush(flush),
      .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
      .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
      .id_link_address(id_link_address), .id_inst(id_inst), .id_pc(id_pc),
      .id_excepttype(id_excepttype), .id_is_in_delayslot(id_is_in_delayslot),
      .id_next_inst_in_delayslot(id_next_inst_in_delayslot),
      .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
      .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .ex_link_address(ex_link_address), .ex_inst(ex_inst), .ex_pc(ex_pc),
      .ex_excepttype(ex_excepttype), .ex_is_in_delayslot(ex_is_in_delayslot),
`ifdef ID_EX_PERF_CNT_EN
      .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
      .is_in_delayslot_o(is_in_delayslot_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      stall_id = 0; stall_ex = 0; flush = 0;
   endtask

   task automatic test_reset();
      rst = 1; set_idle();
      id_valid = 1; id_aluop = 8'hFF; id_alusel = 3'h7; id_reg1 = 32'h1111_1111;
      id_reg2 = 32'h2222_2222; id_wd = 5'd31; id_wreg = 1; id_link_address = 32'h3333_3333;
      id_inst = 32'h4444_4444; id_pc = 32'h5555_5555; id_excepttype = 32'h0000_0200;
      id_is_in_delayslot = 1; id_next_inst_in_delayslot = 1;
      step(); step();
      total_cnt++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ex_valid); else pass_cnt++;
      total_cnt++; if (ex_wreg !== 1'b0) $display("FAIL reset_wreg got %b want 0", ex_wreg); else pass_cnt++;
      total_cnt++; if (ex_aluop !== 8'h00) $display("FAIL reset_aluop got %h want 00", ex_aluop); else pass_cnt++;
      total_cnt++; if (ex_reg1 !== 32'h0) $display("FAIL reset_reg1 got %h want 0", ex_reg1); else pass_cnt++;
      total_cnt++; if (ex_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", ex_pc); else pass_cnt++;
      total_cnt++; if (ex_excepttype !== 32'h0) $display("FAIL reset_exc got %h want 0", ex_excepttype); else pass_cnt++;
      total_cnt++; if (ex_is_in_delayslot !== 1'b0) $display("FAIL reset_ex_ds got %b want 0", ex_is_in_delayslot); else pass_cnt++;
      total_cnt++; if (is_in_delayslot_o !== 1'b0) $display("FAIL reset_ds_o got %b want 0", is_in_delayslot_o); else pass_cnt++;
`ifdef ID_EX_PERF_CNT_EN
      total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
      total_cnt++; if (bubble_cnt !== 4'd0) $display("FAIL reset_bubble_cnt got %0d want 0", bubble_cnt); else pass_cnt++;
`endif
      rst = 0; id_aluop = 8'h21; id_wd = 5'd3; id_wreg = 1; id_valid = 1;
      id_is_in_delayslot = 0; id_next_inst_in_delayslot = 0;
      step();
      total_cnt++; if (ex_aluop !== 8'h21) $display("FAIL first_aluop got %h want 21", ex_aluop); else pass_cnt++;
      total_cnt++; if (ex_wd !== 5'd3) $display("FAIL first_wd got %0d want 3", ex_wd); else pass_cnt++;
      total_cnt++; if (ex_wreg !== 1'b1) $display("FAIL first_wreg got %b want 1", ex_wreg); else pass_cnt++;
      total_cnt++; if (ex_valid !== 1'b1) $display("FAIL first_valid got %b want 1", ex_valid); else pass_cnt++;
   endtask

   task automatic test_stall_hold();
      set_idle(); id_reg1 = 32'hDEADBEEF; id_valid = 1;
      step();
      stall_id = 1; stall_ex = 1;
      for (int i = 0; i < 3; i++) begin
         id_reg1 = 32'h1000 + i;
         step();
         total_cnt++;
         if (ex_reg1 !== 32'hDEADBEEF) $display("FAIL hold_reg1[%0d] got %h want deadbeef", i, ex_reg1);
         else pass_cnt++;
      end
`ifdef ID_EX_PERF_CNT_EN
      total_cnt++; if (stall_cnt !== 4'd3) $display("FAIL hold_stall_cnt got %0d want 3", stall_cnt); else pass_cnt++;
`endif
      // Protocol violation (EX stalled, decode running) must still hold.
      stall_id = 0; stall_ex = 1; id_inst = 32'hCAFE_0001;
      step();
      total_cnt++; if (ex_reg1 !== 32'hDEADBEEF) $display("FAIL hold_only_ex got %h want deadbeef", ex_reg1); else pass_cnt++;
      set_idle();
   endtask

   task automatic test_bubble();
      set_idle(); id_valid = 1; id_aluop = 8'h33; id_wreg = 1;
      stall_id = 1;
      step();
      total_cnt++; if (ex_valid !== 1'b0) $display("FAIL bubble_valid got %b want 0", ex_valid); else pass_cnt++;
      total_cnt++; if (ex_wreg !== 1'b0) $display("FAIL bubble_wreg got %b want 0", ex_wreg); else pass_cnt++;
      total_cnt++; if (ex_aluop !== 8'h00) $display("FAIL bubble_aluop got %h want 00", ex_aluop); else pass_cnt++;
      stall_id = 0; id_inst = 32'h3C010001;
      step();
      total_cnt++; if (ex_inst !== 32'h3C010001) $display("FAIL bubble_resume_inst got %h want 3c010001", ex_inst); else pass_cnt++;
      total_cnt++; if (ex_valid !== 1'b1) $display("FAIL bubble_resume_valid got %b want 1", ex_valid); else pass_cnt++;
`ifdef ID_EX_PERF_CNT_EN
      total_cnt++; if (bubble_cnt !== 4'd1) $display("FAIL bubble_cnt got %0d want 1", bubble_cnt); else pass_cnt++;
`endif
   endtask

   task automatic test_delay_slot();
      set_idle(); id_next_inst_in_delayslot = 1; id_is_in_delayslot = 0;
      step();
      total_cnt++; if (is_in_delayslot_o !== 1'b1) $display("FAIL ds_set got %b want 1", is_in_delayslot_o); else pass_cnt++;
      stall_id = 1; id_next_inst_in_delayslot = 0;
      step();
      total_cnt++; if (is_in_delayslot_o !== 1'b1) $display("FAIL ds_bubble_hold got %b want 1", is_in_delayslot_o); else pass_cnt++;
      stall_id = 0; id_is_in_delayslot = 1; id_next_inst_in_delayslot = 0;
      step();
      total_cnt++; if (ex_is_in_delayslot !== 1'b1) $display("FAIL ds_ex got %b want 1", ex_is_in_delayslot); else pass_cnt++;
      total_cnt++; if (is_in_delayslot_o !== 1'b0) $display("FAIL ds_clear got %b want 0", is_in_delayslot_o); else pass_cnt++;
      id_is_in_delayslot = 0;
   endtask

   task automatic test_flush_stall();
      set_idle(); id_valid = 1; id_aluop = 8'h44; id_excepttype = 32'h0000_0100;
      id_next_inst_in_delayslot = 1;
      step();
      total_cnt++; if (ex_excepttype !== 32'h0000_0100) $display("FAIL flush_pre_exc got %h want 00000100", ex_excepttype); else pass_cnt++;
      stall_ex = 1; stall_id = 1; flush = 1;
      step();
      total_cnt++; if (ex_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", ex_valid); else pass_cnt++;
      total_cnt++; if (ex_excepttype !== 32'h0) $display("FAIL flush_exc got %h want 0", ex_excepttype); else pass_cnt++;
      total_cnt++; if (ex_aluop !== 8'h00) $display("FAIL flush_aluop got %h want 00", ex_aluop); else pass_cnt++;
      total_cnt++; if (is_in_delayslot_o !== 1'b0) $display("FAIL flush_ds got %b want 0", is_in_delayslot_o); else pass_cnt++;
`ifdef ID_EX_PERF_CNT_EN
      total_cnt++; if (stall_cnt !== 4'd4) $display("FAIL flush_stall_cnt got %0d want 4", stall_cnt); else pass_cnt++;
`endif
      set_idle(); id_next_inst_in_delayslot = 0; id_excepttype = 0;
   endtask

   task automatic test_invalid_write();
      set_idle(); id_valid = 0; id_wreg = 1; id_aluop = 8'h55; id_wd = 5'd9;
      step();
      total_cnt++; if (ex_wreg !== 1'b0) $display("FAIL inv_wreg got %b want 0", ex_wreg); else pass_cnt++;
      total_cnt++; if (ex_valid !== 1'b0) $display("FAIL inv_valid got %b want 0", ex_valid); else pass_cnt++;
      total_cnt++; if (ex_aluop !== 8'h55) $display("FAIL inv_aluop got %h want 55", ex_aluop); else pass_cnt++;
      total_cnt++; if (ex_wd !== 5'd9) $display("FAIL inv_wd got %0d want 9", ex_wd); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] r2_tab[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
      logic [31:0] pc_tab[4] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C};
      logic [2:0]  sel_tab[4] = '{3'd1, 3'd7, 3'd0, 3'd4};
      set_idle(); id_valid = 1; id_wreg = 1;
      for (int i = 0; i < 4; i++) begin
         id_reg2 = r2_tab[i]; id_pc = pc_tab[i]; id_alusel = sel_tab[i];
         id_link_address = pc_tab[i] + 32'd8;
         step();
         total_cnt++;
         if (ex_reg2 !== r2_tab[i] || ex_pc !== pc_tab[i] || ex_alusel !== sel_tab[i]
             || ex_link_address !== pc_tab[i] + 32'd8 || ex_wreg !== 1'b1)
            $display("FAIL b2b[%0d] got reg2=%h pc=%h sel=%0d link=%h wreg=%b want reg2=%h pc=%h sel=%0d link=%h wreg=1",
                     i, ex_reg2, ex_pc, ex_alusel, ex_link_address, ex_wreg,
                     r2_tab[i], pc_tab[i], sel_tab[i], pc_tab[i] + 32'd8);
         else pass_cnt++;
      end
   endtask

`ifdef ID_EX_PERF_CNT_EN
   task automatic test_saturation();
      set_idle(); stall_id = 1; stall_ex = 1;
      for (int i = 0; i < 20; i++) step();
      total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt got %0d want 15", stall_cnt); else pass_cnt++;
      step();
      total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt_stay got %0d want 15", stall_cnt); else pass_cnt++;
      total_cnt++; if (bubble_cnt !== 4'd2) $display("FAIL sat_bubble_cnt got %0d want 2", bubble_cnt); else pass_cnt++;
      set_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_stall_hold();
      test_bubble();
      test_delay_slot();
      test_flush_stall();
      test_invalid_write();
      test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
      test_saturation();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline register, the next generation of the fixed-width ID/EX latch.
- Adds per-stage stall, flush, bubble insertion, a valid bit, and exception/PC sideband.
- Registers the branch delay-slot flag and feeds it back to decode.
- Sits between the decode stage and the execute stage. Stall and flush come from the pipeline controller.

Parameters:
- ALUOP_W, 8, width of ALU operation code
- ALUSEL_W, 3, width of ALU result-select code
- DATA_W, 32, width of operands, link address, instruction and PC
- RADDR_W, 5, width of destination register address
- EXC_W, 32, width of exception-type vector
- CNT_W, 32, width of performance counters (used only with PERF_CNT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- stall_id  in  1  decode stage stalled
- stall_ex  in  1  execute stage stalled
- flush  in  1  exception flush; kills the instruction entering EX
- id_valid  in  1  decode holds a real instruction
- id_aluop  in  ALUOP_W  operation code
- id_alusel  in  ALUSEL_W  result select
- id_reg1, id_reg2  in  DATA_W  source operands
- id_wd  in  RADDR_W  destination register
- id_wreg  in  1  register write enable
- id_link_address  in  DATA_W  return address for link instructions
- id_inst  in  DATA_W  raw instruction word
- id_pc  in  DATA_W  instruction address
- id_excepttype  in  EXC_W  exception flags collected in decode
- id_is_in_delayslot  in  1  current decode instruction is in a delay slot
- id_next_inst_in_delayslot  in  1  decode instruction is a branch/jump
- ex_valid  out  1  EX holds a real instruction
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_address, ex_inst, ex_pc, ex_excepttype  out  as inputs  registered copies
- ex_is_in_delayslot  out  1  registered delay-slot flag of the EX instruction
- is_in_delayslot_o  out  1  fed back to decode: the next decoded instruction is in a delay slot
- bubble_cnt, stall_cnt  out  CNT_W  performance counters (present only with PERF_CNT_EN)

Behaviour:
- All state updates on rising clk. Latency is 1 cycle, ID to EX.
- Per-cycle action is chosen by priority, first match wins: rst, flush, hold, bubble, advance.
- rst=1:
  - ex_valid=0, ex_wreg=0, ex_is_in_delayslot=0, is_in_delayslot_o=0.
  - All other ex_* outputs =0. A NOP is aluop 0, alusel 0, wd 0.
  - Counters =0.
- flush=1:
  - Load NOP: same values as reset.
  - Overrides stall_ex. A stalled instruction is still killed.
  - Counters keep their values.
- Hold (stall_ex=1): every register, including is_in_delayslot_o, keeps its value.
- Bubble (stall_id=1, stall_ex=0):
  - Load NOP into EX: ex_valid=0, ex_wreg=0, fields 0.
  - is_in_delayslot_o holds. The branch is re-presented when decode un-stalls.
- Advance (neither stall):
  - Copy all id_* to ex_*. ex_valid<=id_valid.
  - is_in_delayslot_o<=id_next_inst_in_delayslot.
- id_valid=0 on advance:
  - ex_wreg is forced to 0 regardless of id_wreg.
  - Other fields copied unchanged, for debug.
- Decode runs while EX is stalled? Not allowed. stall_ex=1 implies stall_id=1 from the controller. The block still obeys the priority above if violated.
- No combinational path from any input to any output.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, bubble_cnt and stall_cnt exist:
  - bubble_cnt increments on each bubble cycle.
  - stall_cnt increments on each hold cycle.
  - Both saturate at 2^CNT_W-1.
  - Both cleared only by rst.
- When undefined:
  - Ports bubble_cnt and stall_cnt are absent.
  - No counter logic.
  - All other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles with id_* nonzero -> all ex_* =0, ex_valid=0, is_in_delayslot_o=0. Deassert with id_aluop=8'h21, id_wd=5'd3, id_wreg=1, id_valid=1 -> next edge ex_aluop=8'h21, ex_wd=3, ex_wreg=1, ex_valid=1.
- Stall hold: EX holds ex_reg1=32'hDEADBEEF; stall_ex=stall_id=1 for 3 cycles while id_reg1 changes -> ex_reg1 stays 32'hDEADBEEF. With PERF, stall_cnt=3.
- Bubble: stall_id=1, stall_ex=0 for 1 cycle -> ex_valid=0, ex_wreg=0, ex_aluop=0. Next cycle, no stall, id_inst=32'h3C010001 -> ex_inst=32'h3C010001. With PERF, bubble_cnt=1.
- Delay slot: advance with id_next_inst_in_delayslot=1 -> is_in_delayslot_o=1. Next advance with id_is_in_delayslot=1, id_next_inst_in_delayslot=0 -> ex_is_in_delayslot=1, is_in_delayslot_o=0.
- Flush vs stall: stall_ex=1 and flush=1 same cycle, EX valid -> EX becomes NOP, ex_valid=0, ex_excepttype=0, is_in_delayslot_o=0.
- Invalid write: id_valid=0, id_wreg=1, advance -> ex_wreg=0, ex_valid=0.
- Saturation (PERF, CNT_W=4): 20 consecutive hold cycles -> stall_cnt=15 and stays 15.
